// File: rtl/red_pitaya_pwm_dac_n_if.sv
// System-bus port bundle for the N-channel PWM DAC register bank.
interface red_pitaya_pwm_dac_n_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_pwm_dac_n.sv
// N-channel PWM DAC: programmable frame period, per-channel duty targets with
// a once-per-frame slew limiter, and a single-cycle-ack register bank.
module red_pitaya_pwm_dac_n #(
    parameter int          CHN      = 4,
    parameter int          PW       = 8,
    parameter int unsigned RST_DUTY = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [CHN-1:0]        pwm_o,
    output logic                  frame_o,
    red_pitaya_pwm_dac_n_if.slave sys
);
    localparam logic [PW-1:0] DUTY0 = PW'(RST_DUTY);

    logic [PW-1:0]  r_cnt, r_period_r, r_period_a, r_step;
    logic [CHN-1:0] r_en, r_pwm;
    logic [PW-1:0]  r_tgt [CHN];
    logic [PW-1:0]  r_cur [CHN];
    logic           r_frame, r_ack, r_err;
    logic [31:0]    r_rdata;

    logic           w_boundary;
    logic [PW-1:0]  w_cnt_next;
    logic [PW-1:0]  w_cur_next [CHN];
    logic [CHN-1:0] w_status;
    logic [19:0]    w_addr;
    logic           w_access, w_hit, w_ro, w_err, w_wr;
    logic           w_dec_ctrl, w_dec_period, w_dec_step;
    logic [CHN-1:0] w_dec_tgt;
    logic [31:0]    w_rd;
    logic           w_unused;

    // One slew step toward tgt, computed one bit wider so the distance never wraps.
    function automatic logic [PW-1:0] f_slew(input logic [PW-1:0] cur,
                                             input logic [PW-1:0] tgt,
                                             input logic [PW-1:0] step);
        logic [PW:0] diff;
        if (step == '0) return tgt;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            return (diff > {1'b0, step}) ? cur + step : tgt;
        end
        diff = {1'b0, cur} - {1'b0, tgt};
        return (diff > {1'b0, step}) ? cur - step : tgt;
    endfunction

    assign w_boundary = (r_cnt == r_period_a);
    assign w_cnt_next = w_boundary ? '0 : r_cnt + 1'b1;

    always_comb begin
        // NOTE: defaults first, so no branch leaves a bit unassigned and no latch appears.
        w_status = '0;
        for (int n = 0; n < CHN; n++) begin
            w_cur_next[n] = w_boundary ? f_slew(r_cur[n], r_tgt[n], r_step) : r_cur[n];
            w_status[n]   = (r_cur[n] != r_tgt[n]);
        end
    end

    assign w_addr   = sys.sys_addr[19:0];
    assign w_access = sys.sys_wen | sys.sys_ren;

    always_comb begin
        w_dec_ctrl   = (w_addr == 20'h00000);
        w_dec_period = (w_addr == 20'h00004);
        w_dec_step   = (w_addr == 20'h00008);
        w_hit        = w_dec_ctrl | w_dec_period | w_dec_step;
        w_ro         = 1'b0;
        w_dec_tgt    = '0;
        w_rd         = '0;
        if (w_dec_ctrl)   w_rd = 32'(r_en);
        if (w_dec_period) w_rd = 32'(r_period_r);
        if (w_dec_step)   w_rd = 32'(r_step);
        if (w_addr == 20'h0000C) begin
            w_hit = 1'b1;
            w_ro  = 1'b1;
            w_rd  = 32'(w_status);
        end
        for (int n = 0; n < CHN; n++) begin
            if (w_addr == 20'(32'h20 + 4 * n)) begin
                w_dec_tgt[n] = 1'b1;
                w_hit        = 1'b1;
                w_rd         = 32'(r_tgt[n]);
            end
            if (w_addr == 20'(32'h40 + 4 * n)) begin
                w_hit = 1'b1;
                w_ro  = 1'b1;
                w_rd  = 32'(r_cur[n]);
            end
        end
        w_err = w_access & (~w_hit | (sys.sys_wen & w_ro));
        w_wr  = sys.sys_wen & ~w_err;
    end

    // Frame counter, slewed duty and registered PWM compare share the frame timing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_period_a <= '1;
            r_frame    <= 1'b0;
            r_pwm      <= '0;
            // NOTE: the duty arrays are ordinary per-channel flops, not a RAM, so they take the async reset too.
            for (int n = 0; n < CHN; n++) r_cur[n] <= DUTY0;
        end else begin
            // NOTE: non-blocking throughout, so every register sees pre-edge values of its neighbours.
            r_cnt   <= w_cnt_next;
            r_frame <= w_boundary;
            if (w_boundary) r_period_a <= r_period_r;
            for (int n = 0; n < CHN; n++) begin
                r_cur[n] <= w_cur_next[n];
                r_pwm[n] <= r_en[n] & (w_cnt_next < w_cur_next[n]);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_period_r <= '1;
            r_step     <= '0;
            r_en       <= '1;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            for (int n = 0; n < CHN; n++) r_tgt[n] <= DUTY0;
        end else begin
            r_ack   <= w_access;
            r_err   <= w_err;
            r_rdata <= (w_access & ~w_err) ? w_rd : '0;
            if (w_wr & w_dec_ctrl)   r_en       <= sys.sys_wdata[CHN-1:0];
            if (w_wr & w_dec_period) r_period_r <= sys.sys_wdata[PW-1:0];
            if (w_wr & w_dec_step)   r_step     <= sys.sys_wdata[PW-1:0];
            for (int n = 0; n < CHN; n++) begin
                if (w_wr & w_dec_tgt[n]) r_tgt[n] <= sys.sys_wdata[PW-1:0];
            end
        end
    end

    assign pwm_o         = r_pwm;
    assign frame_o       = r_frame;
    assign sys.sys_ack   = r_ack;
    assign sys.sys_err   = r_err;
    assign sys.sys_rdata = r_rdata;

    assign w_unused = ^{sys.sys_addr[31:20], sys.sys_wdata};
endmodule
